rle_stream_scheduler: RTL and testbench

- Sits between the three-stream run-length encoder and a single downstream consumer, such as the decoder input FIFO or a UART/Avalon bridge.
- Buffers the 10-bit run words from each stream in per-stream FIFOs.
- Merges the streams round-robin into one tagged output with a valid/ready handshake.
- Sequences frame boundaries: on `frame_end`, it drains only the words belonging to the ending frame, then emits one frame-marker word.

---
 rtl/rle_stream_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_rle_stream_scheduler.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rle_stream_scheduler.sv
// Buffers three run-word streams, merges them round-robin into one tagged output
// and closes each frame with a marker word once that frame's words have drained.
// state | meaning
// RUN   | merge any buffered words; frame_end snapshots occupancy
// DRAIN | only words counted in the snapshot are eligible
// MARK  | emit the frame marker, then resume RUN
module rle_stream_scheduler #(
  parameter int RUN_W = 10,
  parameter int DEPTH = 8
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [3*RUN_W-1:0] s_data,
  input  logic [2:0]         s_valid,
  input  logic               frame_end,
  output logic [RUN_W+1:0]   m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               overflow,
  output logic               busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int FW = RUN_W - 1;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_MARK  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [RUN_W-1:0] mem_q [3][DEPTH];
  logic [AW-1:0]    wr_ptr_q [3];
  logic [AW-1:0]    wr_ptr_d [3];
  logic [AW-1:0]    rd_ptr_q [3];
  logic [AW-1:0]    rd_ptr_d [3];
  logic [CW-1:0]    cnt_q [3];
  logic [CW-1:0]    cnt_d [3];
  logic [CW-1:0]    pend_q [3];
  logic [CW-1:0]    pend_d [3];
  logic [1:0]       rr_q, rr_d;
  logic             fe_pend_q, fe_pend_d;
  logic             ovf_q, ovf_d;
  logic [FW-1:0]    frame_cnt_q, frame_cnt_d;
  logic [RUN_W+1:0] m_data_q, m_data_d;
  logic             m_valid_q, m_valid_d;

  logic [2:0]       push_ok, pop, elig;
  logic             load_ok, gnt_found, mark_load, fe_drop, cnt_all_zero;
  logic [1:0]       gnt_idx, cand;
  logic [RUN_W-1:0] rd_word;

  // FIFO bookkeeping and round-robin grant
  always_comb begin
    load_ok   = !m_valid_q || m_ready;
    gnt_found = 1'b0;
    gnt_idx   = 2'd0;
    cand      = 2'd0;
    rd_word   = '0;
    pop       = '0;
    for (int k = 0; k < 3; k++) begin
      push_ok[k] = s_valid[k] && (cnt_q[k] != CW'(DEPTH));
      elig[k]    = (state_q == ST_RUN)   ? (cnt_q[k] != '0) :
                   (state_q == ST_DRAIN) ? (pend_q[k] != '0) : 1'b0;
    end
    for (int i = 1; i <= 3; i++) begin
      cand = 2'((int'(rr_q) + i) % 3);
      for (int k = 0; k < 3; k++) begin
        if (!gnt_found && cand == 2'(k) && elig[k]) begin
          gnt_found = 1'b1;
          gnt_idx   = cand;
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      if (gnt_idx == 2'(k)) rd_word = mem_q[k][rd_ptr_q[k]];
      pop[k]      = load_ok && gnt_found && (gnt_idx == 2'(k));
      cnt_d[k]    = cnt_q[k] + CW'(push_ok[k]) - CW'(pop[k]);
      wr_ptr_d[k] = push_ok[k] ? wr_ptr_q[k] + AW'(1) : wr_ptr_q[k];
      rd_ptr_d[k] = pop[k] ? rd_ptr_q[k] + AW'(1) : rd_ptr_q[k];
    end
    mark_load    = (state_q == ST_MARK) && load_ok;
    cnt_all_zero = (cnt_d[0] == '0) && (cnt_d[1] == '0) && (cnt_d[2] == '0);
  end

  // Frame sequencing and output register
  always_comb begin
    state_d     = state_q;
    fe_pend_d   = fe_pend_q;
    fe_drop     = 1'b0;
    frame_cnt_d = frame_cnt_q;
    rr_d        = rr_q;
    m_data_d    = m_data_q;
    m_valid_d   = m_valid_q;
    for (int k = 0; k < 3; k++) pend_d[k] = pend_q[k];

    if (load_ok && gnt_found) begin
      m_data_d  = {gnt_idx, rd_word};
      m_valid_d = 1'b1;
      rr_d      = gnt_idx;
    end else if (mark_load) begin
      m_data_d  = {2'b11, ovf_q, frame_cnt_q};
      m_valid_d = 1'b1;
    end else if (m_ready) begin
      m_valid_d = 1'b0;
    end

    case (state_q)
      ST_RUN: begin
        if (frame_end || fe_pend_q) begin
          for (int k = 0; k < 3; k++) pend_d[k] = cnt_d[k];
          // a fresh pulse arriving with a queued one stays queued
          fe_pend_d = fe_pend_q && frame_end;
          state_d   = cnt_all_zero ? ST_MARK : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        for (int k = 0; k < 3; k++) pend_d[k] = pend_q[k] - CW'(pop[k]);
        if ((pend_d[0] == '0) && (pend_d[1] == '0) && (pend_d[2] == '0))
          state_d = ST_MARK;
      end
      ST_MARK: begin
        if (mark_load) begin
          state_d     = ST_RUN;
          frame_cnt_d = frame_cnt_q + FW'(1);
        end
      end
      default: state_d = ST_RUN;
    endcase

    if (state_q != ST_RUN && frame_end) begin
      if (fe_pend_q) fe_drop = 1'b1;
      else           fe_pend_d = 1'b1;
    end

    ovf_d = mark_load ? 1'b0 : ovf_q;
    if ((|(s_valid & ~push_ok)) || fe_drop) ovf_d = 1'b1;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= ST_RUN;
      rr_q        <= 2'd2;
      fe_pend_q   <= 1'b0;
      ovf_q       <= 1'b0;
      frame_cnt_q <= '0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      for (int k = 0; k < 3; k++) begin
        wr_ptr_q[k] <= '0;
        rd_ptr_q[k] <= '0;
        cnt_q[k]    <= '0;
        pend_q[k]   <= '0;
      end
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      fe_pend_q   <= fe_pend_d;
      ovf_q       <= ovf_d;
      frame_cnt_q <= frame_cnt_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      for (int k = 0; k < 3; k++) begin
        wr_ptr_q[k] <= wr_ptr_d[k];
        rd_ptr_q[k] <= rd_ptr_d[k];
        cnt_q[k]    <= cnt_d[k];
        pend_q[k]   <= pend_d[k];
      end
    end
  end

  always_ff @(posedge CLK) begin
    for (int k = 0; k < 3; k++)
      if (push_ok[k]) mem_q[k][wr_ptr_q[k]] <= s_data[k*RUN_W +: RUN_W];
  end

  assign m_data   = m_data_q;
  assign m_valid  = m_valid_q;
  assign overflow = ovf_q;
  assign busy     = (state_q != ST_RUN);

endmodule

// File: tb/tb_rle_stream_scheduler.sv
// Bench for rle_stream_scheduler: cycle vectors, directed frame corner cases,
// and random traffic against a per-stream queue model with frame tagging.
module tb_rle_stream_scheduler;
  localparam int RUN_W = 10;
  localparam int DEPTH = 8;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [29:0] s_data;
  logic [2:0]  s_valid;
  logic        frame_end;
  logic [11:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        overflow;
  logic        busy;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  rle_stream_scheduler #(.RUN_W(RUN_W), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RESET(RESET), .s_data(s_data), .s_valid(s_valid),
    .frame_end(frame_end), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .overflow(overflow), .busy(busy)
  );

  typedef struct {
    logic [2:0]  sv;
    logic [9:0]  d0, d1, d2;
    logic        fe, rdy, ev;
    logic [11:0] ed;
    logic        eb, eo;
  } vec_t;

  typedef struct {
    logic [9:0] d;
    int         tag;
  } mw_t;

  vec_t        vt[20];
  logic [11:0] got[$];
  logic        ovf_at[$];
  mw_t         mq[3][$];
  int          fe_acc, mk_acc;

  function automatic vec_t mk(logic [2:0] sv, logic [9:0] d0, logic [9:0] d1,
                              logic [9:0] d2, logic fe, logic rdy, logic ev,
                              logic [11:0] ed, logic eb, logic eo);
    vec_t v;
    v.sv = sv; v.d0 = d0; v.d1 = d1; v.d2 = d2; v.fe = fe; v.rdy = rdy;
    v.ev = ev; v.ed = ed; v.eb = eb; v.eo = eo;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(logic [2:0] sv, logic [9:0] d0, logic [9:0] d1,
                       logic [9:0] d2, logic fe, logic rdy);
    s_valid   = sv;
    s_data    = {d2, d1, d0};
    frame_end = fe;
    m_ready   = rdy;
  endtask

  task automatic do_reset();
    drive(3'b000, 10'd0, 10'd0, 10'd0, 1'b0, 1'b1);
    RESET = 1'b1;
    tick();
    tick();
    @(negedge CLK);
    RESET = 1'b0;
    #4;
  endtask

  // Accept n words with m_ready held high; each visible word transfers at the next edge.
  task automatic collect(int n, int budget);
    got.delete();
    ovf_at.delete();
    drive(3'b000, 10'd0, 10'd0, 10'd0, 1'b0, 1'b1);
    for (int c = 0; c < budget && got.size() < n; c++) begin
      if (m_valid) begin
        got.push_back(m_data);
        ovf_at.push_back(overflow);
      end
      tick();
    end
    checks++;
    if (got.size() != n) begin
      failures++;
      $display("FAIL collect_count: got %0d words expected %0d", got.size(), n);
    end
  endtask

  function automatic int tag_left(int t);
    int n = 0;
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < mq[k].size(); j++)
        if (mq[k][j].tag == t) n++;
    return n;
  endfunction

  task automatic model_accept(logic [11:0] w);
    mw_t front;
    logic ok;
    checks++;
    if (w[11:10] == 2'b11) begin
      ok = (fe_acc > mk_acc) && (w[9:0] == {1'b0, 9'(mk_acc)}) && (tag_left(mk_acc) == 0);
      if (!ok) begin
        failures++;
        $display("FAIL rand_marker: got %0h expected marker for frame %0d (frames closed %0d)",
                 w, mk_acc, fe_acc);
      end
      mk_acc++;
    end else if (mq[w[11:10]].size() == 0) begin
      failures++;
      $display("FAIL rand_word: got %0h expected nothing from stream %0d", w, w[11:10]);
    end else begin
      front = mq[w[11:10]].pop_front();
      ok = (front.d == w[9:0]) &&
           ((front.tag == mk_acc) || (front.tag == -1 && fe_acc == mk_acc));
      if (!ok) begin
        failures++;
        $display("FAIL rand_word: got %0h expected payload %0h tag %0d (open marker %0d)",
                 w, front.d, front.tag, mk_acc);
      end
    end
  endtask

  initial begin
    logic [2:0] sv;
    logic [9:0] rd [3];
    logic       fe, rdy, quiet;
    mw_t        t;

    vt[0]  = mk(3'b111, 10'd5,  10'd7, 10'd9,  1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0);
    vt[1]  = mk(3'b000, 10'd0,  10'd0, 10'd0,  1'b0, 1'b1, 1'b1, 12'h005, 1'b0, 1'b0);
    vt[2]  = mk(3'b000, 10'd0,  10'd0, 10'd0,  1'b0, 1'b1, 1'b1, 12'h407, 1'b0, 1'b0);
    vt[3]  = mk(3'b000, 10'd0,  10'd0, 10'd0,  1'b0, 1'b1, 1'b1, 12'h809, 1'b0, 1'b0);
    vt[4]  = mk(3'b000, 10'd0,  10'd0, 10'd0,  1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0);
    vt[5]  = mk(3'b001, 10'd11, 10'd0, 10'd0,  1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0);
    vt[6]  = mk(3'b001, 10'd12, 10'd0, 10'd0,  1'b0, 1'b1, 1'b1, 12'h00B, 1'b0, 1'b0);
    vt[7]  = mk(3'b001, 10'd13, 10'd0, 10'd0,  1'b1, 1'b1, 1'b1, 12'h00C, 1'b1, 1'b0);
    vt[8]  = mk(3'b100, 10'd0,  10'd0, 10'd20, 1'b0, 1'b1, 1'b1, 12'h00D, 1'b1, 1'b0);
    vt[9]  = mk(3'b000, 10'd0,  10'd0, 10'd0,  1'b0, 1'b1, 1'b1, 12'hC00, 1'b0, 1'b0);
    vt[10] = mk(3'b000, 10'd0,  10'd0, 10'd0,  1'b0, 1'b1, 1'b1, 12'h814, 1'b0, 1'b0);
    vt[11] = mk(3'b000, 10'd0,  10'd0, 10'd0,  1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0);
    vt[12] = mk(3'b010, 10'd0,  10'd3, 10'd0,  1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0);
    vt[13] = mk(3'b010, 10'd0,  10'd4, 10'd0,  1'b0, 1'b0, 1'b1, 12'h403, 1'b0, 1'b0);
    vt[14] = mk(3'b010, 10'd0,  10'd6, 10'd0,  1'b0, 1'b0, 1'b1, 12'h403, 1'b0, 1'b0);
    vt[15] = mk(3'b000, 10'd0,  10'd0, 10'd0,  1'b0, 1'b0, 1'b1, 12'h403, 1'b0, 1'b0);
    vt[16] = mk(3'b000, 10'd0,  10'd0, 10'd0,  1'b0, 1'b0, 1'b1, 12'h403, 1'b0, 1'b0);
    vt[17] = mk(3'b000, 10'd0,  10'd0, 10'd0,  1'b0, 1'b1, 1'b1, 12'h404, 1'b0, 1'b0);
    vt[18] = mk(3'b000, 10'd0,  10'd0, 10'd0,  1'b0, 1'b1, 1'b1, 12'h406, 1'b0, 1'b0);
    vt[19] = mk(3'b000, 10'd0,  10'd0, 10'd0,  1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0);

    RESET = 1'b1;
    drive(3'b000, 10'd0, 10'd0, 10'd0, 1'b0, 1'b1);
    tick();
    check("reset_m_valid", m_valid, 0);
    check("reset_m_data", m_data, 0);
    check("reset_busy", busy, 0);
    check("reset_overflow", overflow, 0);
    @(negedge CLK);
    RESET = 1'b0;
    #4;

    // Cycle-exact vectors: fan-in order, latency, frame close, stall hold
    for (int i = 0; i < 20; i++) begin
      drive(vt[i].sv, vt[i].d0, vt[i].d1, vt[i].d2, vt[i].fe, vt[i].rdy);
      tick();
      check($sformatf("vec%0d_valid", i), m_valid, vt[i].ev);
      if (vt[i].ev) check($sformatf("vec%0d_data", i), m_data, vt[i].ed);
      check($sformatf("vec%0d_busy", i), busy, vt[i].eb);
      check($sformatf("vec%0d_overflow", i), overflow, vt[i].eo);
    end

    // Overfill stream 2 while stalled: one word in the output register, eight buffered, one dropped
    for (int i = 0; i < 10; i++) begin
      drive(3'b100, 10'd0, 10'd0, 10'(100 + i), 1'b0, 1'b0);
      tick();
      if (i == 8) check("ovf_at_full", overflow, 0);
    end
    check("ovf_after_drop", overflow, 1);
    check("ovf_held_word", m_data, 12'h864);
    drive(3'b000, 10'd0, 10'd0, 10'd0, 1'b1, 1'b0);
    tick();
    check("ovf_busy_drain", busy, 1);
    collect(10, 40);
    for (int i = 0; i < got.size(); i++)
      check($sformatf("ovf_out%0d", i), got[i], (i < 9) ? 12'h864 + 12'(i) : 12'hE01);
    if (got.size() == 10) begin
      check("ovf_before_marker", ovf_at[0], 1);
      check("ovf_cleared_at_marker", ovf_at[9], 0);
    end
    tick();
    check("ovf_idle_busy", busy, 0);
    check("ovf_idle_valid", m_valid, 0);

    // Three frame_end pulses in one DRAIN: second queued, third dropped
    for (int i = 0; i < 3; i++) begin
      drive(3'b001, 10'(200 + i), 10'd0, 10'd0, 1'b0, 1'b0);
      tick();
    end
    drive(3'b000, 10'd0, 10'd0, 10'd0, 1'b1, 1'b0);
    tick();
    check("fe3_busy", busy, 1);
    tick();
    check("fe3_queued_no_ovf", overflow, 0);
    tick();
    check("fe3_dropped_ovf", overflow, 1);
    collect(5, 40);
    for (int i = 0; i < got.size(); i++)
      check($sformatf("fe3_out%0d", i), got[i],
            (i < 3) ? 12'h0C8 + 12'(i) : (i == 3) ? 12'hE02 : 12'hC03);
    tick();
    check("fe3_idle_busy", busy, 0);
    check("fe3_idle_ovf", overflow, 0);

    // Reset mid-frame with a held word, buffered words, DRAIN and overflow all live
    for (int i = 0; i < 10; i++) begin
      drive(3'b001, 10'(300 + i), 10'd0, 10'd0, 1'b0, 1'b0);
      tick();
    end
    drive(3'b000, 10'd0, 10'd0, 10'd0, 1'b1, 1'b0);
    tick();
    check("mid_pre_busy", busy, 1);
    check("mid_pre_ovf", overflow, 1);
    frame_end = 1'b0;
    #2;
    RESET = 1'b1;
    #1;
    check("mid_async_valid", m_valid, 0);
    check("mid_async_busy", busy, 0);
    check("mid_async_ovf", overflow, 0);
    check("mid_async_data", m_data, 0);
    tick();
    @(negedge CLK);
    RESET = 1'b0;
    drive(3'b000, 10'd0, 10'd0, 10'd0, 1'b0, 1'b1);
    quiet = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (m_valid) quiet = 1'b0;
    end
    check("mid_no_stale", quiet, 1);
    drive(3'b010, 10'd0, 10'd77, 10'd0, 1'b1, 1'b1);
    tick();
    collect(2, 20);
    if (got.size() == 2) begin
      check("mid_word_after", got[0], 12'h44D);
      check("mid_marker_after", got[1], 12'hC00);
    end

    // Randomized traffic against the queue model
    do_reset();
    fe_acc = 0;
    mk_acc = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      sv = 3'b000;
      for (int k = 0; k < 3; k++) begin
        rd[k] = 10'($urandom_range(0, 1023));
        if ($urandom_range(0, 3) == 0 && mq[k].size() < DEPTH) sv[k] = 1'b1;
      end
      fe  = (fe_acc == mk_acc) && ($urandom_range(0, 39) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      drive(sv, rd[0], rd[1], rd[2], fe, rdy);
      if (m_valid && m_ready) model_accept(m_data);
      for (int k = 0; k < 3; k++)
        if (sv[k]) begin
          t.d = rd[k];
          t.tag = -1;
          mq[k].push_back(t);
        end
      if (fe) begin
        for (int k = 0; k < 3; k++)
          for (int j = 0; j < mq[k].size(); j++)
            if (mq[k][j].tag == -1) begin
              t = mq[k][j];
              t.tag = fe_acc;
              mq[k][j] = t;
            end
        fe_acc++;
      end
      tick();
    end
    drive(3'b000, 10'd0, 10'd0, 10'd0, 1'b0, 1'b1);
    for (int c = 0; c < 300; c++) begin
      if (mq[0].size() + mq[1].size() + mq[2].size() == 0 && fe_acc == mk_acc && !m_valid) break;
      if (m_valid && m_ready) model_accept(m_data);
      tick();
    end
    check("rand_left_words", mq[0].size() + mq[1].size() + mq[2].size(), 0);
    check("rand_open_frames", fe_acc - mk_acc, 0);
    check("rand_saw_frames", (fe_acc > 3) ? 1 : 0, 1);
    check("rand_overflow", overflow, 0);
    check("rand_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
